// File: rtl/instr_load_pkg.sv
// instr_load_pkg: shared types and widths for the instruction-memory loader.
package instr_load_pkg;
   localparam int INSTR_W     = 32;
   localparam int LOAD_ADDR_W = 9;
   typedef enum logic [2:0] {IDLE, FILL1, FILL2, WRITE, DONE} loader_state_t;
endpackage

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: packs a word stream into pairs and writes them to the instruction memory load port.
module instr_mem_loader
   import instr_load_pkg::*;
#(
   parameter int ADDR_W    = LOAD_ADDR_W,
   parameter int CNT_W     = 10,
   parameter int ADDR_STEP = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [ADDR_W-1:0]    base_addr,
   input  logic [CNT_W-1:0]     word_count,
   input  logic                 in_valid,
   input  logic [INSTR_W-1:0]   in_data,
   output logic                 in_ready,
   output logic                 enable_load_ex_mem,
   output logic [ADDR_W-1:0]    InstExMemAddress,
   output logic [INSTR_W-1:0]   InstExMemData1,
   output logic [INSTR_W-1:0]   InstExMemData2,
   output logic                 enable_half,
   output logic                 busy,
   output logic                 done
);
   loader_state_t        state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d, oaddr_q;
   logic [CNT_W-1:0]     rem_q, rem_d, rem_dec;
   logic [INSTR_W-1:0]   d1_q, d1_d, d2_q, d2_d;
   logic                 half_q, half_d, en_q, eh_q, busy_q, done_q;

   assign rem_dec  = rem_q - CNT_W'(1);
   assign in_ready = (state_q == FILL1) || (state_q == FILL2);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      d1_d    = d1_q;
      d2_d    = d2_q;
      half_d  = half_q;
      case (state_q)
         IDLE: if (start) begin
            addr_d  = base_addr;
            rem_d   = word_count;
            state_d = (word_count == '0) ? DONE : FILL1;
         end
         FILL1: if (in_valid) begin
            d1_d    = in_data;
            d2_d    = '0;
            rem_d   = rem_dec;
            half_d  = (rem_dec == '0);
            state_d = (rem_dec == '0) ? WRITE : FILL2;
         end
         FILL2: if (in_valid) begin
            d2_d    = in_data;
            rem_d   = rem_dec;
            half_d  = 1'b0;
            state_d = WRITE;
         end
         WRITE: begin
            addr_d  = addr_q + ADDR_W'(ADDR_STEP);
            state_d = (rem_q == '0) ? DONE : FILL1;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= '0;
         oaddr_q <= '0;
         rem_q   <= '0;
         d1_q    <= '0;
         d2_q    <= '0;
         half_q  <= 1'b0;
         en_q    <= 1'b0;
         eh_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         d1_q    <= d1_d;
         d2_q    <= d2_d;
         half_q  <= half_d;
         en_q    <= (state_d == WRITE);
         eh_q    <= (state_d == WRITE) && half_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= (state_d == DONE);
         if (state_d == WRITE) oaddr_q <= addr_d;
      end
   end

   assign enable_load_ex_mem = en_q;
   assign enable_half        = eh_q;
   assign InstExMemAddress   = oaddr_q;
   assign InstExMemData1     = d1_q;
   assign InstExMemData2     = d2_q;
   assign busy               = busy_q;
   assign done               = done_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: directed loads checked against a scoreboard of expected pair writes.
module tb_instr_mem_loader;
   typedef struct {
      logic [8:0]  addr;
      logic [31:0] d1;
      logic [31:0] d2;
      logic        half;
   } wr_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [8:0]  base_addr = '0;
   logic [9:0]  word_count = '0;
   logic        in_valid = 1'b0;
   logic [31:0] in_data = '0;
   logic        in_ready, enable_load_ex_mem, enable_half, busy, done;
   logic [8:0]  InstExMemAddress;
   logic [31:0] InstExMemData1, InstExMemData2;

   int vectors = 0;
   int errs = 0;
   int cyc = 0;
   int nstrobe = 0;
   int t0, dc, ns;
   wr_t sb[$];

   instr_mem_loader dut (
      .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
      .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .enable_load_ex_mem(enable_load_ex_mem), .InstExMemAddress(InstExMemAddress),
      .InstExMemData1(InstExMemData1), .InstExMemData2(InstExMemData2),
      .enable_half(enable_half), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (enable_load_ex_mem) begin
         wr_t e;
         nstrobe++;
         chk("strobe_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wr_addr", 64'(InstExMemAddress), 64'(e.addr));
            chk("wr_d1", 64'(InstExMemData1), 64'(e.d1));
            chk("wr_d2", 64'(InstExMemData2), 64'(e.d2));
            chk("wr_half", 64'(enable_half), 64'(e.half));
         end
      end
   end

   task automatic push(input logic [8:0] a, input logic [31:0] x, input logic [31:0] y, input logic h);
      wr_t e;
      e.addr = a; e.d1 = x; e.d2 = y; e.half = h;
      sb.push_back(e);
   endtask

   task automatic start_load(input logic [8:0] b, input logic [9:0] c);
      base_addr = b; word_count = c; start = 1'b1; t0 = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send(input logic [31:0] w, input int gaps);
      int k = 0;
      in_valid = 1'b0;
      repeat (gaps) @(negedge clk);
      in_valid = 1'b1; in_data = w;
      while (in_ready !== 1'b1 && k < 50) begin
         @(negedge clk);
         k++;
      end
      chk("accept_in_time", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_done(output int d);
      int k = 0;
      while (done !== 1'b1 && k < 100) begin
         @(negedge clk);
         k++;
      end
      chk("done_seen", 64'(done), 64'd1);
      d = cyc;
      @(negedge clk);
      chk("done_one_cycle", 64'(done), 64'd0);
      chk("idle_after_done", 64'(busy), 64'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_ready"}, 64'(in_ready), 64'd0);
      chk({tag, "_en"}, 64'(enable_load_ex_mem), 64'd0);
      chk({tag, "_half"}, 64'(enable_half), 64'd0);
      chk({tag, "_busy"}, 64'(busy), 64'd0);
      chk({tag, "_done"}, 64'(done), 64'd0);
      chk({tag, "_addr"}, 64'(InstExMemAddress), 64'd0);
      chk({tag, "_d1"}, 64'(InstExMemData1), 64'd0);
      chk({tag, "_d2"}, 64'(InstExMemData2), 64'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      start = 1'b1; base_addr = 9'h1FF; word_count = 10'd4;
      repeat (2) @(negedge clk);
      chk_zero("reset");
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("rst_with_start_idle", 64'(busy), 64'd0);

      // even load, in_valid held high
      push(9'd0, 32'hA0, 32'hA1, 1'b0);
      push(9'd1, 32'hA2, 32'hA3, 1'b0);
      start_load(9'd0, 10'd4);
      chk("busy_in_fill", 64'(busy), 64'd1);
      for (int i = 0; i < 4; i++) send(32'hA0 + 32'(i), 0);
      wait_done(dc);
      chk("even_latency", 64'(dc - t0), 64'(3 * 2 + 2 - 1));
      chk("even_sb_empty", 64'(sb.size()), 64'd0);

      // odd load: last pair is a half write
      push(9'h10, 32'h11, 32'h22, 1'b0);
      push(9'h11, 32'h33, 32'h0, 1'b1);
      start_load(9'h10, 10'd3);
      send(32'h11, 0); send(32'h22, 0); send(32'h33, 0);
      wait_done(dc);
      chk("odd_sb_empty", 64'(sb.size()), 64'd0);

      // backpressure
      push(9'd0, 32'hA0, 32'hA1, 1'b0);
      push(9'd1, 32'hA2, 32'hA3, 1'b0);
      start_load(9'd0, 10'd4);
      send(32'hA0, 0); send(32'hA1, 2); send(32'hA2, 1); send(32'hA3, 2);
      wait_done(dc);
      chk("bp_sb_empty", 64'(sb.size()), 64'd0);

      // zero count
      ns = nstrobe;
      start_load(9'd7, 10'd0);
      wait_done(dc);
      chk("zero_latency", 64'(dc - t0), 64'd1);
      chk("zero_no_strobe", 64'(nstrobe - ns), 64'd0);

      // start during FILL1 is ignored
      push(9'h40, 32'hC0, 32'hC1, 1'b0);
      start_load(9'h40, 10'd2);
      chk("fill1_ready", 64'(in_ready), 64'd1);
      base_addr = 9'h80; word_count = 10'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      send(32'hC0, 0); send(32'hC1, 0);
      wait_done(dc);
      chk("ign_sb_empty", 64'(sb.size()), 64'd0);

      // address wrap
      push(9'd511, 32'hE0, 32'hE1, 1'b0);
      push(9'd0, 32'hE2, 32'hE3, 1'b0);
      start_load(9'd511, 10'd4);
      for (int i = 0; i < 4; i++) send(32'hE0 + 32'(i), 0);
      wait_done(dc);
      chk("wrap_sb_empty", 64'(sb.size()), 64'd0);

      // reset mid-load
      ns = nstrobe;
      start_load(9'd0, 10'd4);
      send(32'hF0, 0);
      chk("in_fill2", 64'(in_ready), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      chk_zero("midrst");
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_no_strobe", 64'(nstrobe - ns), 64'd0);
      push(9'd5, 32'h55, 32'h66, 1'b0);
      start_load(9'd5, 10'd2);
      send(32'h55, 0); send(32'h66, 0);
      wait_done(dc);
      chk("final_sb_empty", 64'(sb.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/instr_mem_loader.md
Name: instr_mem_loader

Overview:
- Producer side of the instruction-memory load port; drives the memory's load address, the two data words and the load enable.
- Accepts a valid/ready stream of 32-bit instruction words, for example from a UART or testbench source.
- Packs the words in pairs, issues one load write per pair at consecutive addresses, then releases the memory to the PC-driven fetch path.
- Sits between the program source and the instruction memory; the core is held off the memory while the loader is busy.

Parameters:
- ADDR_W, 9, width of the load address (matches the instruction-memory load port).
- CNT_W, 10, width of the word-count input.
- ADDR_STEP, 1, address increment applied after each pair write.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a load; sampled only in IDLE.
- base_addr  in  ADDR_W  first load address; latched on start.
- word_count  in  CNT_W  number of 32-bit words to load; latched on start.
- in_valid  in  1  stream word valid.
- in_data  in  32  stream instruction word.
- in_ready  out  1  loader accepts in_data this cycle.
- enable_load_ex_mem  out  1  load-write strobe; while high the memory is in write mode and ignores fetch.
- InstExMemAddress  out  ADDR_W  load address.
- InstExMemData1  out  32  first (lower-address) word of the pair.
- InstExMemData2  out  32  second word of the pair.
- enable_half  out  1  high with the strobe when only Data1 is valid (odd final word).
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the load completes.

Behaviour:
- Reset: synchronous, active-high, overrides every other input. State goes to IDLE. All outputs are 0: in_ready, enable_load_ex_mem, enable_half, busy, done, address, Data1, Data2.
- Reset mid-load aborts the load; the partially written memory contents are left as-is.
- All outputs are registered, except in_ready, which decodes the current state (FILL1 or FILL2).
- State IDLE:
  - On start=1 the loader latches base_addr into addr and word_count into rem.
  - If word_count==0 it goes to DONE; otherwise it goes to FILL1.
  - start in any other state is ignored.
- State FILL1 (in_ready=1):
  - On in_valid, Data1 <- in_data, Data2 <- 0, rem <- rem-1.
  - If the new rem==0, go to WRITE with half=1; otherwise go to FILL2.
  - Without in_valid the loader holds state with no timeout.
- State FILL2 (in_ready=1):
  - On in_valid, Data2 <- in_data, rem <- rem-1, half=0, go to WRITE.
- State WRITE (one cycle):
  - enable_load_ex_mem=1, InstExMemAddress=addr, enable_half=half; Data1 and Data2 are stable.
  - Next cycle addr <- addr+ADDR_STEP, modulo 2^ADDR_W (silent wrap: 511+1 gives 0).
  - Go to DONE if rem==0, else go to FILL1.
- State DONE: done=1 for exactly one cycle, then IDLE.
- enable_load_ex_mem and enable_half are 0 outside WRITE.
- Data1, Data2 and InstExMemAddress keep their last values outside WRITE; the memory ignores them when the strobe is low.
- Throughput and latency:
  - Minimum 3 cycles per pair: FILL1, FILL2, WRITE with in_valid held high.
  - A 2N-word load takes 3N+2 cycles from start to the done pulse, counting the IDLE->FILL1 cycle and the DONE cycle.
- Simultaneous events:
  - in_valid in WRITE or DONE is not accepted (in_ready=0), so the source must hold the word.
  - rst together with start results in IDLE.

Decomposition:
- Shared package instr_load_pkg holds:
  - the state enum loader_state_t {IDLE, FILL1, FILL2, WRITE, DONE};
  - constants INSTR_W=32 and LOAD_ADDR_W=9.
- Single module; no sub-module is warranted, because the FSM, address counter and remaining counter are small.

Test Plan:
- Even load: rst 2 cycles, start with base=0, count=4, stream 0xA0..0xA3 with in_valid constant. Required: two strobes, (addr 0, D1=0xA0, D2=0xA1, half=0) and (addr 1, 0xA2, 0xA3, half=0). done pulses at cycle 3·2+2=8 after start.
- Odd load: base=0x10, count=3, words 0x11,0x22,0x33. Required: second strobe at addr 0x11 with D1=0x33, D2=0, enable_half=1; done then busy=0.
- Backpressure: same as the even case with in_valid toggled 1,0,0,1,... Required: words captured only when in_valid&in_ready, no strobe until both words of a pair are held, and the final data is identical to the even case.
- Zero count and ignored start: count=0 gives done one cycle after the IDLE cycle with no strobe. A start pulse during FILL1 changes neither addr nor rem.
- Wrap: base=511, count=4. Required: strobes at addr 511 then 0.
- Reset mid-load: rst asserted in FILL2 after one word. Required: all outputs 0 next cycle and no strobe. A new start (base=5, count=2) then completes normally at addr 5.
